// File: rtl/rr_grant_pkg.sv
// Shared types and search helpers for the round-robin grant arbiter.
// The helpers work on a MAX_WIDTH-wide vector, so arbiter widths up to 256 are supported.
package rr_grant_pkg;

   localparam int MAX_WIDTH = 256;
   localparam int MAX_LOG   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic               found;
      logic [MAX_LOG-1:0] idx;
   } search_t;

   // Explicit wrap, so a non-power-of-2 width never lands on an unused index.
   function automatic int next_ptr(input int idx, input int width);
      return (idx == width - 1) ? 0 : idx + 1;
   endfunction

   // Bits above the caller's width are zero, so scanning the full MAX_WIDTH
   // ring gives the same order as scanning ptr..width-1, 0..ptr-1.
   function automatic search_t rr_search(input logic [MAX_WIDTH-1:0] vec,
                                         input logic [MAX_LOG-1:0]   ptr);
      search_t res;
      int      pos;
      res = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         pos = (int'(ptr) + i) % MAX_WIDTH;
         if (!res.found && vec[pos]) begin
            res.found = 1'b1;
            res.idx   = MAX_LOG'(pos);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_grant_decoder.sv
// Index-to-one-hot decoder with enable; used for both the grant vector and the
// per-requester ready.
module grant_decoder #(
   parameter  int WIDTH     = 8,
   localparam int WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic [WIDTH_LOG-1:0] idx,
   input  logic                 en,
   output logic [WIDTH-1:0]     onehot
);

   always_comb begin
      // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
      onehot = '0;
      for (int i = 0; i < WIDTH; i++) begin
         onehot[i] = en && (idx == WIDTH_LOG'(i));
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Sequential round-robin arbiter with valid/ready grant handshake.
// Define RR_GRANT_ARBITER_LOCK_EN to add gnt_lst and hold ownership for multi-beat packets.
module rr_grant_arbiter
   import rr_grant_pkg::*;
#(
   parameter  int WIDTH     = 8,
   localparam int WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef RR_GRANT_ARBITER_LOCK_EN
   input  logic                 gnt_lst,
`endif
   input  logic [WIDTH-1:0]     req_vld,
   output logic [WIDTH-1:0]     req_rdy,
   output logic                 gnt_vld,
   input  logic                 gnt_rdy,
   output logic [WIDTH_LOG-1:0] gnt_idx,
   output logic [WIDTH-1:0]     gnt_onehot,
   output logic [WIDTH_LOG-1:0] pri
);

   state_e               state;
   logic                 xfer;
   logic                 last;
   logic                 adv;
   logic [WIDTH_LOG-1:0] pri_nxt;
   logic [WIDTH-1:0]     cand;
   search_t              win;
   logic [WIDTH_LOG-1:0] win_idx;
   logic                 unused_win_bits;

`ifdef RR_GRANT_ARBITER_LOCK_EN
   assign last = gnt_lst;
`else
   assign last = 1'b1;
`endif

   assign gnt_vld = (state == GRANT);
   assign xfer    = gnt_vld & gnt_rdy;
   assign adv     = xfer & last;
   assign pri_nxt = WIDTH_LOG'(next_ptr(int'(gnt_idx), WIDTH));

   // In IDLE gnt_onehot is zero, so one search serves both the first grant and
   // re-arbitration (current winner masked, searched from the advanced pointer).
   assign cand            = req_vld & ~gnt_onehot;
   assign win             = rr_search(MAX_WIDTH'(cand), MAX_LOG'(gnt_vld ? pri_nxt : pri));
   assign win_idx         = WIDTH_LOG'(win.idx);
   assign unused_win_bits = ^win.idx;

   grant_decoder #(.WIDTH(WIDTH)) u_gnt_dec (
      .idx    (gnt_idx),
      .en     (gnt_vld),
      .onehot (gnt_onehot)
   );

   grant_decoder #(.WIDTH(WIDTH)) u_rdy_dec (
      .idx    (gnt_idx),
      .en     (xfer),
      .onehot (req_rdy)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt_idx <= '0;
         pri     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win.found) begin
                  gnt_idx <= win_idx;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (adv) begin
                  pri <= pri_nxt;
                  if (win.found) gnt_idx <= win_idx;
                  else           state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed self-checking bench for rr_grant_arbiter (WIDTH=8).
// The lock scenario runs only when RR_GRANT_ARBITER_LOCK_EN is defined.
module tb_rr_grant_arbiter;

   localparam int WIDTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_vld;
   logic [7:0] req_rdy;
   logic       gnt_vld;
   logic       gnt_rdy;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_onehot;
   logic [2:0] pri;
`ifdef RR_GRANT_ARBITER_LOCK_EN
   logic       gnt_lst;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   rr_grant_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef RR_GRANT_ARBITER_LOCK_EN
      .gnt_lst    (gnt_lst),
`endif
      .req_vld    (req_vld),
      .req_rdy    (req_rdy),
      .gnt_vld    (gnt_vld),
      .gnt_rdy    (gnt_rdy),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .pri        (pri)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [2:0] idx, input logic [2:0] p);
      check({tag, "_vld"}, gnt_vld, 1'b1);
      check({tag, "_idx"}, gnt_idx, idx);
      check({tag, "_onehot"}, gnt_onehot, 8'h01 << idx);
      check({tag, "_pri"}, pri, p);
   endtask

   task automatic check_idle(input string tag, input logic [2:0] p);
      check({tag, "_vld"}, gnt_vld, 1'b0);
      check({tag, "_onehot"}, gnt_onehot, 8'h00);
      check({tag, "_rdy"}, req_rdy, 8'h00);
      check({tag, "_pri"}, pri, p);
   endtask

   initial begin
      rst_n   = 1'b0;
      req_vld = 8'h00;
      gnt_rdy = 1'b0;
`ifdef RR_GRANT_ARBITER_LOCK_EN
      gnt_lst = 1'b1;
`endif
      #2;
      check_idle("rst", 3'd0);
      check("rst_idx", gnt_idx, 3'd0);
      #10 rst_n = 1'b1;

      // Idle: no requests for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_idle("idle", 3'd0);
      end

      // Two requesters, back-to-back grants, then back to IDLE.
      req_vld = 8'h24;
      gnt_rdy = 1'b1;
      #1 check("pre24_vld", gnt_vld, 1'b0);
      tick();
      check_grant("g24_a", 3'd2, 3'd0);
      check("g24_a_rdy", req_rdy, 8'h04);
      tick();
      req_vld = 8'h20;
      check_grant("g24_b", 3'd5, 3'd3);
      tick();
      req_vld = 8'h00;
      check_idle("g24_end", 3'd6);

      // Pointer at 6: grant 6 then wrap to 0.
      req_vld = 8'h41;
      tick();
      check_grant("g41_a", 3'd6, 3'd6);
      tick();
      req_vld = 8'h01;
      check_grant("g41_b", 3'd0, 3'd7);
      tick();
      req_vld = 8'h00;
      check_idle("g41_end", 3'd1);

      // Stalled grant on 3 must hold while 7 arrives.
      req_vld = 8'h08;
      gnt_rdy = 1'b0;
      tick();
      check_grant("stall0", 3'd3, 3'd1);
      check("stall0_rdy", req_rdy, 8'h00);
      req_vld = 8'h88;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_grant("stall", 3'd3, 3'd1);
         check("stall_rdy", req_rdy, 8'h00);
      end
      gnt_rdy = 1'b1;
      #1 check("stall_rel_rdy", req_rdy, 8'h08);
      tick();
      req_vld = 8'h80;
      check_grant("after_stall", 3'd7, 3'd4);
      tick();
      req_vld = 8'h00;
      check_idle("stall_end", 3'd0);

      // All eight requesting: strict rotation, then async reset mid-sequence.
      req_vld = 8'hFF;
      tick();
      for (int k = 0; k < 5; k++) begin
         check_grant("rot", 3'(k), 3'(k));
         check("rot_rdy", req_rdy, 8'h01 << k);
         tick();
         req_vld[k] = 1'b0;
      end
      check_grant("rot5", 3'd5, 3'd5);
      #2 rst_n = 1'b0;
      #1;
      check_idle("mid_rst", 3'd0);
      check("mid_rst_idx", gnt_idx, 3'd0);
      tick();
      check_idle("mid_rst_hold", 3'd0);
      #2 rst_n = 1'b1;
      #1 check_idle("post_rst", 3'd0);
      tick();
      check_grant("resume5", 3'd5, 3'd0);
      tick();
      req_vld = 8'hC0;
      check_grant("resume6", 3'd6, 3'd6);
      tick();
      req_vld = 8'h80;
      check_grant("resume7", 3'd7, 3'd7);
      tick();
      req_vld = 8'h00;
      check_idle("resume_end", 3'd0);

`ifdef RR_GRANT_ARBITER_LOCK_EN
      // Requester 2 owns the port for three beats while 4 waits.
      req_vld = 8'h14;
      gnt_lst = 1'b0;
      tick();
      check_grant("lock_b0", 3'd2, 3'd0);
      tick();
      check_grant("lock_b1", 3'd2, 3'd0);
      tick();
      gnt_lst = 1'b1;
      check_grant("lock_b2", 3'd2, 3'd0);
      tick();
      req_vld = 8'h10;
      check_grant("lock_next", 3'd4, 3'd3);
      tick();
      req_vld = 8'h00;
      check_idle("lock_end", 3'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Sequential round-robin arbiter: WIDTH requesters with valid/ready handshakes share one downstream port.
- Keeps the rotating priority pointer that a programmable priority encoder consumes.
- Registers the winner and decodes its index back into a one-hot grant and per-requester ready.
- Sits in front of shared resources (bus port, FIFO write side) as the grant-issuing end of the request/priority scheme.

Parameters:
- WIDTH, 8, number of requesters; any value ≥ 2.
- WIDTH_LOG, $clog2(WIDTH), localparam, width of index and pointer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_vld  input  WIDTH  per-requester request valid.
- req_rdy  output  WIDTH  per-requester ready; one-hot or zero.
- gnt_vld  output  1  a grant is presented downstream.
- gnt_rdy  input  1  downstream accepts the grant.
- gnt_idx  output  WIDTH_LOG  index of the granted requester.
- gnt_onehot  output  WIDTH  one-hot decode of gnt_idx, gated by gnt_vld.
- pri  output  WIDTH_LOG  current priority pointer; this index has highest priority.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt_vld=0, gnt_idx=0, gnt_onehot=0, pri=0, req_rdy=0. Reset mid-grant drops the grant immediately; no transfer is counted.
- Search: scan indices pri, pri+1, ... WIDTH-1, 0, ... pri-1, with wrap modulo WIDTH. The first index with a set bit in the candidate vector wins.
- IDLE:
  - If |req_vld, register winner(req_vld) into gnt_idx and go to GRANT. gnt_vld rises the next cycle (1-cycle latency from request to grant).
  - Otherwise stay in IDLE.
- GRANT:
  - gnt_vld=1; gnt_onehot=1<<gnt_idx; req_rdy=gnt_onehot & {WIDTH{gnt_rdy}} (combinational pass-through of gnt_rdy).
  - Transfer = gnt_vld & gnt_rdy. On transfer, pri <= (gnt_idx==WIDTH-1) ? 0 : gnt_idx+1. Explicit wrap; correct for non-power-of-2 WIDTH.
  - On transfer, the candidate vector is req_vld with bit gnt_idx masked, searched against the updated pointer.
    - Nonzero candidate: load new winner, stay in GRANT (back-to-back, no bubble).
    - Zero candidate: go to IDLE.
  - A single requester streaming alone is therefore served every other cycle. This is intended; it bounds the combinational path.
  - No transfer: gnt_idx, gnt_onehot and pri hold. The grant must not change while gnt_vld & !gnt_rdy.
- Requester rule: once req_vld[i] is set it stays set until req_rdy[i]. Withdrawal is a protocol violation; the arbiter must not hang, and drops the grant after the next transfer.
- Simultaneous requests from all WIDTH requesters are served in strict rotation; each waits at most WIDTH-1 transfers.
- gnt_onehot and req_rdy are never multi-hot; gnt_onehot=0 whenever gnt_vld=0.

Optional Feature:
- Macro: RR_GRANT_ARBITER_LOCK_EN.
- Defined:
  - Adds input port gnt_lst (1 bit, last beat of packet).
  - A transfer with gnt_lst=0 keeps gnt_idx, pri and GRANT unchanged, so the same requester keeps ownership for multi-beat packets.
  - Only a transfer with gnt_lst=1 advances pri and runs the re-arbitration above.
- Undefined: no gnt_lst port; every transfer is treated as last.

Decomposition:
- Shared package rr_grant_pkg:
  - State enum typedef (IDLE, GRANT).
  - Function next_ptr(idx, width) implementing the wrap.
  - Function rr_search(vec, ptr) returning {found, idx}.
- One natural sub-module: grant_decoder. Maps a WIDTH_LOG index plus enable to a WIDTH one-hot vector; used for both gnt_onehot and req_rdy.

Test Plan:
- Reset, then req_vld=8'h00 for 5 cycles -> gnt_vld=0, req_rdy=0, pri=0 throughout.
- req_vld=8'h24, gnt_rdy=1 continuously -> gnt_idx=2 then 5 on consecutive cycles, no bubble; pri goes 0 -> 3 -> 6; then IDLE.
- pri=6 with req_vld=8'h41 -> grant 6 first, then 0 (wrap); pri ends at 1.
- Grant to index 3 with gnt_rdy=0 for 4 cycles while req_vld[7] rises -> gnt_idx stays 3, gnt_onehot stays 8'h08; index 7 is granted only after the transfer.
- All 8 requesting, gnt_rdy=1 -> grants in order 0,1,...,7; rst_n pulsed low mid-sequence -> outputs cleared asynchronously and pri=0 after release.
- With RR_GRANT_ARBITER_LOCK_EN, requester 2 sends 3 beats (gnt_lst=0,0,1) while requester 4 is waiting -> gnt_idx=2 for all 3 beats, then 4.
